// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline memory stage.
//   DW / RW      : default data/address width and register-index width
//   mem_state_e  : data-memory access FSM encoding (IDLE, WAIT, DONE)
//   branch_taken : PCSrc decode for BEQ/BNE
package mips_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  function automatic logic branch_taken(input logic br, input logic bne, input logic zero);
    return (br & zero) | (bne & ~zero);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
//   load_i      : capture every field from the MEM stage (WB_MemData only when md_load_i)
//   bubble_i    : insert a bubble (RegWrite and jal cleared, other fields held)
//   *_i / *_o   : control (RegWrite, Mem2R, jal) and data (AluRes, MemData, NPC, Wesel)
// Asynchronous active-high reset clears every field.
module mem_wb_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          bubble_i,
  input  logic          md_load_i,
  input  logic          regwrite_i,
  input  logic          mem2r_i,
  input  logic          jal_i,
  input  logic [DW-1:0] alures_i,
  input  logic [DW-1:0] memdata_i,
  input  logic [DW-1:0] npc_i,
  input  logic [RW-1:0] wesel_i,
  output logic          regwrite_o,
  output logic          mem2r_o,
  output logic          jal_o,
  output logic [DW-1:0] alures_o,
  output logic [DW-1:0] memdata_o,
  output logic [DW-1:0] npc_o,
  output logic [RW-1:0] wesel_o
);

  logic          regwrite_q, mem2r_q, jal_q;
  logic [DW-1:0] alures_q, memdata_q, npc_q;
  logic [RW-1:0] wesel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      mem2r_q    <= 1'b0;
      jal_q      <= 1'b0;
      alures_q   <= '0;
      memdata_q  <= '0;
      npc_q      <= '0;
      wesel_q    <= '0;
    end else if (load_i) begin
      regwrite_q <= regwrite_i;
      mem2r_q    <= mem2r_i;
      jal_q      <= jal_i;
      alures_q   <= alures_i;
      npc_q      <= npc_i;
      wesel_q    <= wesel_i;
      if (md_load_i) memdata_q <= memdata_i;
    end else if (bubble_i) begin
      regwrite_q <= 1'b0;
      jal_q      <= 1'b0;
    end
  end

  assign regwrite_o = regwrite_q;
  assign mem2r_o    = mem2r_q;
  assign jal_o      = jal_q;
  assign alures_o   = alures_q;
  assign memdata_o  = memdata_q;
  assign npc_o      = npc_q;
  assign wesel_o    = wesel_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Resolves branches (PCSrc), runs data-memory accesses over a req/ack handshake
// with variable-latency memory, stalls the front of the pipe while an access is
// outstanding, and holds the MEM/WB register.
// Ports:
//   MEM_*            : EX/MEM register outputs (control, AluRes, store data, Wesel, NPC)
//   dm_req/we/addr/wdata (out), dm_rdata/dm_ack (in) : data-memory handshake
//   mem_stall        : hold PC, IF/ID, ID/EX, EX/MEM
//   PCSrc            : branch taken (IDLE only)
//   WB_*             : MEM/WB register outputs
// Build option MEM_ALIGN_CHK_EN: a misaligned memory op issues no request, is
// written back with RegWrite cleared, and pulses the mem_misalign output.
//
// state | meaning
// IDLE  | no access in flight; memory op launches a request at the next edge
// WAIT  | request outstanding, waiting for dm_ack
// DONE  | access complete; instruction written to MEM/WB, pipe released
module mem_stage #(
  parameter int DW = mips_pkg::DW,
  parameter int RW = mips_pkg::RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MEM_Branch,
  input  logic          MEM_BNE,
  input  logic          MEM_MemRead,
  input  logic          MEM_MemWrite,
  input  logic          MEM_Mem2R,
  input  logic          MEM_RegWrite,
  input  logic          MEM_zero,
  input  logic          MEM_jal,
  input  logic [DW-1:0] MEM_AluRes,
  input  logic [DW-1:0] MEM_GPR_Data_2,
  input  logic [RW-1:0] MEM_Wesel,
  input  logic [DW-1:0] MEM_NPC,
  output logic          dm_req,
  output logic          dm_we,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  input  logic          dm_ack,
  output logic          mem_stall,
  output logic          PCSrc,
`ifdef MEM_ALIGN_CHK_EN
  output logic          mem_misalign,
`endif
  output logic          WB_RegWrite,
  output logic          WB_Mem2R,
  output logic          WB_jal,
  output logic [DW-1:0] WB_AluRes,
  output logic [DW-1:0] WB_MemData,
  output logic [DW-1:0] WB_NPC,
  output logic [RW-1:0] WB_Wesel
);

  import mips_pkg::*;

  mem_state_e    state_q, state_d;
  logic          dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [DW-1:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [DW-1:0] rbuf_q, rbuf_d;
  logic          stall, pcsrc, wb_load, wb_bubble, md_load, rw_kill;
  logic          mem_op, misalign;

  assign mem_op = MEM_MemRead | MEM_MemWrite;

`ifdef MEM_ALIGN_CHK_EN
  logic misalign_q;
  assign misalign = mem_op & (MEM_AluRes[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= (state_q == IDLE) & misalign;
  end

  assign mem_misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    rbuf_d     = rbuf_q;
    stall      = 1'b0;
    pcsrc      = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    md_load    = 1'b0;
    rw_kill    = 1'b0;
    case (state_q)
      IDLE: begin
        pcsrc = branch_taken(MEM_Branch, MEM_BNE, MEM_zero);
        if (misalign) begin
          // Dropped access: retire the instruction without a register write.
          wb_load = 1'b1;
          rw_kill = 1'b1;
        end else if (mem_op) begin
          stall      = 1'b1;
          wb_bubble  = 1'b1;
          state_d    = WAIT;
          dm_req_d   = 1'b1;
          dm_we_d    = MEM_MemWrite;
          dm_addr_d  = {MEM_AluRes[DW-1:2], 2'b00};
          dm_wdata_d = MEM_GPR_Data_2;
        end else begin
          wb_load = 1'b1;
        end
      end
      WAIT: begin
        stall     = 1'b1;
        wb_bubble = 1'b1;
        if (dm_ack) begin
          dm_req_d = 1'b0;
          state_d  = DONE;
          if (!dm_we_q) rbuf_d = dm_rdata;
        end
      end
      DONE: begin
        // EX/MEM still holds the memory instruction this cycle.
        wb_load = 1'b1;
        md_load = ~dm_we_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      rbuf_q     <= '0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      rbuf_q     <= rbuf_d;
    end
  end

  // Combinational outputs are gated so every output reads 0 while in reset.
  assign mem_stall = stall & ~rst;
  assign PCSrc     = pcsrc & ~rst;
  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;

  mem_wb_reg #(.DW(DW), .RW(RW)) u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wb_load),
    .bubble_i   (wb_bubble),
    .md_load_i  (md_load),
    .regwrite_i (MEM_RegWrite & ~rw_kill),
    .mem2r_i    (MEM_Mem2R),
    .jal_i      (MEM_jal),
    .alures_i   (MEM_AluRes),
    .memdata_i  (rbuf_q),
    .npc_i      (MEM_NPC),
    .wesel_i    (MEM_Wesel),
    .regwrite_o (WB_RegWrite),
    .mem2r_o    (WB_Mem2R),
    .jal_o      (WB_jal),
    .alures_o   (WB_AluRes),
    .memdata_o  (WB_MemData),
    .npc_o      (WB_NPC),
    .wesel_o    (WB_Wesel)
  );

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs and resolves branches (PCSrc).
- Performs data-memory load/store over a req/ack handshake with variable-latency memory.
- Drives the EX/MEM write-enable stall while an access is outstanding.
- Contains the MEM/WB pipeline register feeding write-back.

Parameters:
- DW, 32, data/address width.
- RW, 5, register-index width (Wesel).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- MEM_Branch, MEM_BNE, MEM_MemRead, MEM_MemWrite, MEM_Mem2R, MEM_RegWrite, MEM_zero, MEM_jal  in  1 each  control from EX/MEM.
- MEM_AluRes  in  DW  address / ALU result.
- MEM_GPR_Data_2  in  DW  store data.
- MEM_Wesel  in  RW  destination register.
- MEM_NPC  in  DW  PC+4 / branch target.
- dm_req  out  1  memory request (registered).
- dm_we  out  1  1 = write.
- dm_addr  out  DW  word address, {AluRes[DW-1:2],2'b00}.
- dm_wdata  out  DW  store data.
- dm_rdata  in  DW  load data, valid with dm_ack.
- dm_ack  in  1  one-cycle completion pulse.
- mem_stall  out  1  1 = hold PC, IF/ID, ID/EX, EX/MEM (EXMEM_Write = ~mem_stall).
- PCSrc  out  1  branch taken.
- WB_RegWrite, WB_Mem2R, WB_jal  out  1 each  MEM/WB control.
- WB_AluRes, WB_MemData, WB_NPC  out  DW  MEM/WB data.
- WB_Wesel  out  RW  MEM/WB destination.

Behaviour:
- Reset: every output 0, including dm_req/dm_we/dm_addr/dm_wdata; FSM goes to IDLE.
- Reset mid-access drops dm_req immediately and abandons the access; an ack arriving in IDLE is ignored.
- Memory op = MemRead | MemWrite. MemWrite has priority: if both are set, the access is a write and WB_MemData is not updated.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no memory op:
  - mem_stall=0.
  - MEM/WB loads all fields on the next edge.
  - PCSrc = (Branch & zero) | (BNE & ~zero), combinational.
- IDLE, memory op:
  - mem_stall=1 combinationally, same cycle.
  - Next edge: go to WAIT, register dm_req=1, dm_we, dm_addr, dm_wdata.
  - MEM/WB loads a bubble (WB_RegWrite=0, WB_jal=0, other fields unchanged).
- WAIT:
  - mem_stall=1; dm_req/dm_we/dm_addr/dm_wdata held stable.
  - MEM/WB loads a bubble each cycle.
  - On dm_ack: capture dm_rdata into an internal buffer (reads only), clear dm_req at the same edge, go to DONE.
  - No timeout; WAIT is held indefinitely.
- DONE:
  - mem_stall=0.
  - MEM/WB loads the instruction, with WB_MemData taken from the buffer.
  - Next state IDLE. EX/MEM advances at the same edge, so the next instruction is evaluated in IDLE one cycle later.
- Latency: non-memory instruction 1 cycle in MEM. Memory op = 2 + N cycles, where N = cycles from dm_req rise to dm_ack (N≥1); minimum total 3.
- PCSrc is forced 0 outside IDLE. Branches carry no memory op, so they never stall.
- Back-to-back memory ops: DONE→IDLE→WAIT. dm_req is low for at least 2 cycles between accesses.
- dm_ack in the same cycle as rst: rst wins.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - Memory op with MEM_AluRes[1:0]≠0 issues no request and stays in IDLE with mem_stall=0.
  - Extra output mem_misalign (1 bit, registered) pulses 1 for one cycle.
  - MEM/WB loads that instruction with WB_RegWrite=0.
- Undefined:
  - Low address bits are ignored (dm_addr forced word-aligned).
  - No mem_misalign port.

Decomposition:
- Shared package/header mips_pkg: FSM state localparams (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), DW, RW.
- One sub-module, mem_wb_reg: MEM/WB register with load and bubble inputs, async reset.
- FSM, branch logic and dm interface stay in mem_stage.

Test Plan:
- Reset, then ALU op (RegWrite=1, AluRes=0x0000_00AA, Wesel=5) → next edge WB_AluRes=0xAA, WB_Wesel=5, WB_RegWrite=1, mem_stall never 1.
- Load from 0x0000_0010, memory acks 3 cycles after dm_req rise with dm_rdata=0xDEAD_BEEF → mem_stall high 4 cycles, DONE cycle WB_MemData=0xDEADBEEF, WB_RegWrite=1; WB_RegWrite=0 during all stall cycles.
- Store 0x1234_5678 to 0x20, ack after 1 cycle → dm_we=1, dm_addr=0x20, dm_wdata=0x12345678 stable throughout; total stall 2 cycles; WB_MemData unchanged.
- BEQ zero=1 → PCSrc=1. BNE zero=1 → PCSrc=0. BNE zero=0 → PCSrc=1. All with mem_stall=0.
- Assert rst in WAIT, then release; inject stray dm_ack in IDLE → all outputs 0, dm_req stays 0, no MEM/WB update from the stray ack.
- With MEM_ALIGN_CHK_EN: load from 0x0000_0013 → dm_req stays 0, mem_misalign=1 for one cycle, WB_RegWrite=0.
